// File: rtl/memaddr_seq_if.sv
// rtl/memaddr_seq_if.sv - memory address unit signal bundle; COMP_MODE_EN adds comp_mode_h
interface memaddr_seq_if #(
    parameter int AW = 32
);
    logic [AW-1:0] wbus_h;
    logic          ld_pc_h;
    logic          pc_inc_h;
    logic [1:0]    pc_step_h;
    logic          backup_pc_h;
    logic          ld_va_h;
    logic          save_va_h;
    logic [1:0]    ma_sel_h;
    logic          acc_req_h;
    logic [1:0]    acc_size_h;
    logic          acc_ack_h;
    logic [AW-1:0] ma_h;
    logic          acc_busy_h;
    logic          acc_second_h;
    logic          page_boundary_h;
    logic [1:0]    xb_pc_h;
    logic          va_0_h;
`ifdef COMP_MODE_EN
    logic          comp_mode_h;
`endif

    modport slave (
`ifdef COMP_MODE_EN
        input  comp_mode_h,
`endif
        input  wbus_h, ld_pc_h, pc_inc_h, pc_step_h, backup_pc_h, ld_va_h, save_va_h,
        input  ma_sel_h, acc_req_h, acc_size_h, acc_ack_h,
        output ma_h, acc_busy_h, acc_second_h, page_boundary_h, xb_pc_h, va_0_h
    );

    modport master (
`ifdef COMP_MODE_EN
        output comp_mode_h,
`endif
        output wbus_h, ld_pc_h, pc_inc_h, pc_step_h, backup_pc_h, ld_va_h, save_va_h,
        output ma_sel_h, acc_req_h, acc_size_h, acc_ack_h,
        input  ma_h, acc_busy_h, acc_second_h, page_boundary_h, xb_pc_h, va_0_h
    );
endinterface

// File: rtl/memaddr_seq.sv
// rtl/memaddr_seq.sv - PC/VA address unit with unaligned-access split sequencer; COMP_MODE_EN enables 16-bit mode
module memaddr_seq #(
    parameter int AW        = 32,
    parameter int PAGE_BITS = 9,
    parameter int LW_BITS   = 2
) (
    input  logic          b_clk_l,
    input  logic          reset_h,
    memaddr_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CYC1, S_CYC2} state_t;

    localparam int                  SW         = LW_BITS + 4;
    localparam logic [AW-1:0]       LOW16_MASK = AW'(32'h0000_FFFF);
    localparam logic [AW-LW_BITS-1:0] WORD_ONE = 1;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, r_va, r_va_save, r_pc_backup, r_ma;
    logic          r_split, r_second, r_pb, r_busy;

    logic [AW-1:0] w_ma_nxt;
    logic          w_split_nxt, w_second_nxt, w_pb_nxt;
    logic          w_comp;
    logic [AW-1:0] w_src, w_ma_word, w_pc_inc, w_pc_nxt;
    logic [3:0]    w_step_b;
    logic [SW-1:0] w_end;
    logic          w_split_new, w_page_top;

`ifdef COMP_MODE_EN
    assign w_comp = bus.comp_mode_h;
`else
    assign w_comp = 1'b0;
`endif

    function automatic logic [AW-1:0] f_limit(input logic [AW-1:0] a, input logic comp);
        return comp ? (a & LOW16_MASK) : a;
    endfunction

    always_comb begin
        w_src = r_pc;
        case (bus.ma_sel_h)
            2'd0: w_src = r_pc;
            2'd1: w_src = r_va;
            2'd2: w_src = r_va_save;
            2'd3: w_src = r_pc_backup;
            default: w_src = r_pc;
        endcase
    end

    // A split is needed when the access runs past the end of the bus word
    assign w_end       = SW'(w_src[LW_BITS-1:0]) + (SW'(1) << bus.acc_size_h);
    assign w_split_new = w_end > (SW'(1) << LW_BITS);
    assign w_page_top  = &w_src[PAGE_BITS-1:LW_BITS];
    assign w_ma_word   = {r_ma[AW-1:LW_BITS] + WORD_ONE, {LW_BITS{1'b0}}};

    assign w_step_b = 4'd1 << bus.pc_step_h;
    assign w_pc_inc = w_comp ? ((r_pc & ~LOW16_MASK) | ((r_pc + {{(AW-4){1'b0}}, w_step_b}) & LOW16_MASK))
                             : r_pc + {{(AW-4){1'b0}}, w_step_b};
    assign w_pc_nxt = bus.ld_pc_h ? bus.wbus_h : (bus.pc_inc_h ? w_pc_inc : r_pc);

    always_ff @(posedge b_clk_l) begin
        if (reset_h) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.acc_req_h) w_state_nxt = S_CYC1;
            S_CYC1:  if (bus.acc_ack_h) w_state_nxt = r_split ? S_CYC2 : S_IDLE;
            S_CYC2:  if (bus.acc_ack_h) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ma_nxt     = r_ma;
        w_split_nxt  = r_split;
        w_second_nxt = r_second;
        w_pb_nxt     = r_pb;
        case (r_state)
            S_IDLE: begin
                if (bus.acc_req_h) begin
                    w_ma_nxt     = f_limit(w_src, w_comp);
                    w_split_nxt  = w_split_new;
                    w_second_nxt = 1'b0;
                    w_pb_nxt     = w_split_new & w_page_top;
                end
            end
            S_CYC1: begin
                if (bus.acc_ack_h) begin
                    if (r_split) begin
                        w_ma_nxt     = f_limit(w_ma_word, w_comp);
                        w_second_nxt = 1'b1;
                    end else begin
                        w_second_nxt = 1'b0;
                        w_pb_nxt     = 1'b0;
                    end
                end
            end
            S_CYC2: begin
                if (bus.acc_ack_h) begin
                    w_split_nxt  = 1'b0;
                    w_second_nxt = 1'b0;
                    w_pb_nxt     = 1'b0;
                end
            end
            default: begin
                w_second_nxt = 1'b0;
                w_pb_nxt     = 1'b0;
            end
        endcase
    end

    // Save/backup take the pre-edge register values, so same-cycle loads never leak in
    always_ff @(posedge b_clk_l) begin
        if (reset_h) begin
            r_pc        <= '0;
            r_va        <= '0;
            r_va_save   <= '0;
            r_pc_backup <= '0;
            r_ma        <= '0;
            r_split     <= 1'b0;
            r_second    <= 1'b0;
            r_pb        <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_ma     <= w_ma_nxt;
            r_split  <= w_split_nxt;
            r_second <= w_second_nxt;
            r_pb     <= w_pb_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            if (bus.ld_va_h)     r_va        <= bus.wbus_h;
            if (bus.save_va_h)   r_va_save   <= r_va;
            if (bus.backup_pc_h) r_pc_backup <= r_pc;
        end
    end

    assign bus.ma_h            = r_ma;
    assign bus.acc_busy_h      = r_busy;
    assign bus.acc_second_h    = r_second;
    assign bus.page_boundary_h = r_pb;
    assign bus.xb_pc_h         = r_pc[1:0];
    assign bus.va_0_h          = r_va[0];
endmodule
